// File: rtl/pond_feed_fifo_if.sv
// pond_feed_fifo_if: upstream word stream plus pond write-port signals.
//
// Handshake: a word on in_data transfers on a rising clk edge exactly when
// in_valid and in_ready are both 1; in_valid may be raised without waiting
// for in_ready, and in_data must hold while in_valid=1 and in_ready=0.
// sched_valid is a one-cycle, no-backpressure strobe: the pond samples
// data_out in every cycle where it is 1.
interface pond_feed_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  sched_valid;
  logic [DATA_WIDTH-1:0] data_out;

  // Upstream producer / schedule generator / pond side
  modport master (
    output in_data,
    output in_valid,
    output sched_valid,
    input  in_ready,
    input  data_out
  );

  // Feeder FIFO side
  modport slave (
    input  in_data,
    input  in_valid,
    input  sched_valid,
    output in_ready,
    output data_out
  );
endinterface

// File: rtl/pond_feed_fifo.sv
// pond_feed_fifo: buffers an elastic ready/valid word stream and releases
// one word to the pond's write port on each schedule strobe.
// Reset (rst_n) is synchronous and active-high.
// Optional feature macro: POND_FEED_BYPASS_EN -- when the FIFO is empty, a
// word arriving in the same cycle as the strobe goes straight to data_out.
module pond_feed_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tile_en,
  input  logic                   flush,
  pond_feed_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   underflow,
  output logic [CNT_WIDTH-1:0]   words_sent,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [OW-1:0]         count;
  logic [CNT_WIDTH-1:0]  sent_cnt;
  logic                  underflow_q;

  logic empty, full;
  logic bypass, push, pop, deliver, underflow_evt;

  assign empty = (count == '0);
  assign full  = (count == OW'(DEPTH));

  // in_ready comes only from registered state, never from sched_valid.
  assign bus.in_ready = ~rst_n & tile_en & ~flush & ~full;

`ifdef POND_FEED_BYPASS_EN
  assign bypass = ~rst_n & tile_en & ~flush & empty & bus.in_valid & bus.sched_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed directly, so it must not also be stored.
  assign push          = bus.in_valid & bus.in_ready & ~bypass;
  assign pop           = tile_en & ~flush & bus.sched_valid & ~empty;
  assign deliver       = pop | bypass;
  assign underflow_evt = tile_en & ~flush & bus.sched_valid & empty & ~bypass;

  assign bus.data_out = bypass ? bus.in_data :
                        empty  ? '0 : mem[rd_ptr];

  assign occupancy  = count;
  assign underflow  = underflow_q;
  assign words_sent = sent_cnt;
  assign state      = state_q;

  // Storage array: written on accepted pushes only; contents are don't-care
  // while not counted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, delivered-word counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      sent_cnt    <= '0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      sent_cnt    <= '0;
      underflow_q <= 1'b0;
    end else if (tile_en) begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
      if (deliver) begin
        sent_cnt <= sent_cnt + CNT_WIDTH'(1);
      end
      if (underflow_evt) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: ERROR is only left by flush or reset.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (tile_en) begin
      case (state_q)
        IDLE: begin
          if (underflow_evt)  state_d = ERROR;
          else if (deliver)   state_d = ACTIVE;
        end
        ACTIVE: begin
          if (underflow_evt)  state_d = ERROR;
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pond_feed_fifo.sv
// tb_pond_feed_fifo: directed bench for pond_feed_fifo.
module tb_pond_feed_fifo;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tile_en;
  logic        flush;
  logic [3:0]  occupancy;
  logic        underflow;
  logic [15:0] words_sent;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  pond_feed_fifo_if #(.DATA_WIDTH(DW)) bus ();

  pond_feed_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tile_en    (tile_en),
    .flush      (flush),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .underflow  (underflow),
    .words_sent (words_sent),
    .state      (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp3 [5];

  initial begin
    exp3[0] = 16'h0101; exp3[1] = 16'h0202; exp3[2] = 16'h0303;
    exp3[3] = 16'hAAAA; exp3[4] = 16'hAAAA;

    // Reset
    rst_n = 1'b1; tile_en = 1'b1; flush = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.sched_valid = 1'b0;
    tick(); tick();
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_state", state, 0);
    chk("rst_data_out", bus.data_out, 0);
    rst_n = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Fill to full, no strobes
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 16'(i); bus.in_valid = 1'b1;
      tick();
    end
    chk("full_occ", occupancy, 8);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head", bus.data_out, 16'h0001);
    bus.in_data = 16'h0009;
    tick();
    chk("ninth_dropped_occ", occupancy, 8);
    chk("full_state", state, 0);
    bus.in_valid = 1'b0;

    // Drain with strobe every cycle
    bus.sched_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("drain_data", bus.data_out, 16'(i));
      tick();
    end
    bus.sched_valid = 1'b0;
    #1;
    chk("drain_words", words_sent, 8);
    chk("drain_occ", occupancy, 0);
    chk("drain_state", state, 1);
    chk("drain_underflow", underflow, 0);
    chk("empty_data_out", bus.data_out, 0);

    // Flush from ACTIVE
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_state", state, 0);
    chk("flush1_words", words_sent, 0);

    // Occupancy 3, simultaneous push/pop for 5 cycles
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0101; tick();
    bus.in_data = 16'h0202; tick();
    bus.in_data = 16'h0303; tick();
    chk("pp_pre_occ", occupancy, 3);
    bus.in_data = 16'hAAAA; bus.sched_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("pp_data", bus.data_out, exp3[k]);
      chk("pp_occ", occupancy, 3);
      tick();
    end
    chk("pp_words", words_sent, 5);
    chk("pp_occ_after", occupancy, 3);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pp_tail_data", bus.data_out, 16'hAAAA);
      tick();
    end
    bus.sched_valid = 1'b0;
    chk("pp_drain_words", words_sent, 8);
    chk("pp_drain_occ", occupancy, 0);
    chk("pp_drain_state", state, 1);

    // Empty FIFO: strobe together with an incoming word
    bus.in_valid = 1'b1; bus.sched_valid = 1'b1; bus.in_data = 16'h1234;
    #1;
`ifdef POND_FEED_BYPASS_EN
    chk("empty_strobe_data_out", bus.data_out, 16'h1234);
    tick();
    bus.in_valid = 1'b0; bus.sched_valid = 1'b0;
    chk("bypass_words", words_sent, 9);
    chk("bypass_underflow", underflow, 0);
    chk("bypass_occ", occupancy, 0);
`else
    chk("empty_strobe_data_out", bus.data_out, 0);
    tick();
    bus.in_valid = 1'b0; bus.sched_valid = 1'b0;
    chk("uf_underflow", underflow, 1);
    chk("uf_state", state, 2);
    chk("uf_occ", occupancy, 1);
    chk("uf_words", words_sent, 8);
    chk("uf_head", bus.data_out, 16'h1234);
`endif

    // Drive into ERROR in either build, then refill to 4
    bus.sched_valid = 1'b1;
    tick(); tick();
    bus.sched_valid = 1'b0;
    chk("err_underflow", underflow, 1);
    chk("err_state", state, 2);
    chk("err_words", words_sent, 9);
    chk("err_occ0", occupancy, 0);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 16'hC000 + 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("err_occ4", occupancy, 4);
    chk("err_state_hold", state, 2);
    chk("err_head", bus.data_out, 16'hC001);

    // Flush with concurrent push and strobe
    flush = 1'b1; bus.in_valid = 1'b1; bus.sched_valid = 1'b1; bus.in_data = 16'hDEAD;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0; bus.sched_valid = 1'b0;
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_underflow", underflow, 0);
    chk("flush_state", state, 0);
    chk("flush_words", words_sent, 0);
    chk("flush_data_out", bus.data_out, 0);

    // tile_en=0 holds everything
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0B01; tick();
    bus.in_data = 16'h0B02; tick();
    bus.in_valid = 1'b0;
    tile_en = 1'b0; bus.sched_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_head", bus.data_out, 16'h0B01);
      tick();
    end
    chk("hold_occ", occupancy, 2);
    chk("hold_words", words_sent, 0);
    chk("hold_state", state, 0);
    tile_en = 1'b1;
    #1;
    chk("resume_head", bus.data_out, 16'h0B01);
    tick();
    chk("resume_words1", words_sent, 1);
    chk("resume_head2", bus.data_out, 16'h0B02);
    tick();
    bus.sched_valid = 1'b0;
    chk("resume_words2", words_sent, 2);
    chk("resume_occ", occupancy, 0);
    chk("resume_state", state, 1);

    // Reset mid-stream
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0E01; tick();
    bus.in_data = 16'h0E02; tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_occ", occupancy, 2);
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_occ", occupancy, 0);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_words", words_sent, 0);
    chk("midrst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pond_feed_fifo.md
Name: pond_feed_fifo

Overview:
- Transmit-side feeder for the pond's scheduled write port.
- Accepts a ready/valid word stream from upstream and buffers it in a small FIFO.
- Presents the head word to pond data_in and pops exactly on cycles where the write schedule generator asserts its accessor-valid strobe.
- Converts elastic upstream traffic into the pond's statically scheduled, no-backpressure write protocol, and flags schedule underflow.

Parameters:
- DATA_WIDTH, 16, word width; matches pond data_in.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16, width of words_sent counter; matches cycle_count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (asserted = 1)
- tile_en  in  1  enable; when 0 all state holds
- flush  in  1  synchronous clear of FIFO, FSM and flags
- in_data  in  DATA_WIDTH  upstream word
- in_valid  in  1  upstream word valid
- in_ready  out  1  FIFO can accept in_data
- sched_valid  in  1  write-schedule strobe (pond write enable); pond samples data_out this cycle
- data_out  out  DATA_WIDTH  word to pond data_in
- occupancy  out  $clog2(DEPTH)+1  current entry count
- underflow  out  1  sticky: strobe arrived with no data
- words_sent  out  CNT_WIDTH  words delivered to pond, wraps modulo 2^CNT_WIDTH
- state  out  2  FSM state for debug

Behaviour:
- Priority order: rst_n, then flush, then tile_en==0 (hold), then normal operation.
- Reset (rst_n=1 at posedge):
  - Pointers, occupancy, words_sent = 0; underflow = 0; state = IDLE.
  - Outputs during and after reset: in_ready=0 while rst_n=1; data_out=0 while empty.
- Storage: DEPTH x DATA_WIDTH registers; rd_ptr/wr_ptr wrap modulo DEPTH.
- in_ready = tile_en & ~flush & (occupancy != DEPTH). Combinational from registered count; no dependence on sched_valid.
- push = in_valid & in_ready; data is written at the posedge; visible at data_out no earlier than the next cycle. Minimum latency in_data -> data_out is 1 cycle.
- data_out = head entry combinationally when occupancy>0, else 0.
- pop = tile_en & sched_valid & (occupancy>0). rd_ptr advances and words_sent increments at that posedge.
- Simultaneous push+pop: occupancy unchanged; both pointers advance. Legal at any occupancy except full, where push is blocked by in_ready=0.
- Underflow event = tile_en & sched_valid & (occupancy==0). Sets underflow sticky at that posedge; data_out=0 that cycle; words_sent not incremented. A push in the same cycle is still accepted.
- FSM states: IDLE=0, ACTIVE=1, ERROR=2.
  - IDLE -> ACTIVE: first pop.
  - IDLE -> ERROR or ACTIVE -> ERROR: underflow event.
  - ERROR: stays until flush or reset; pushes and pops continue normally in ERROR.
  - Any state -> IDLE: flush.
- flush: pointers, occupancy, underflow, words_sent cleared; state=IDLE. A concurrent push is dropped (in_ready=0); a concurrent sched_valid is ignored.
- tile_en=0: no push, pop, underflow or counter change; sched_valid ignored; data_out still shows head.
- Reset mid-stream: all buffered data discarded; no partial state retained.
- words_sent wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Optional Feature:
- Macro POND_FEED_BYPASS_EN.
- Defined: when occupancy==0 & in_valid & sched_valid & tile_en & ~flush:
  - data_out = in_data combinationally.
  - Word consumed without entering storage: no pointer change; words_sent increments.
  - No underflow event; FSM treats it as a pop.
  - in_ready unchanged by this path.
- Undefined: no bypass path; this case is an underflow event, and in_data is pushed normally.

Test Plan:
- Reset then push 0x0001..0x0008 with sched_valid=0 -> occupancy=8, in_ready=0, in_valid on 9th word not accepted, state=IDLE.
- From full, sched_valid every cycle for 8 cycles -> data_out sequence 0x0001..0x0008 in order, words_sent=8, occupancy=0, state=ACTIVE, underflow=0.
- Occupancy 3, simultaneous push 0xAAAA and sched_valid for 5 cycles -> occupancy stays 3, output order preserved across pointer wrap, words_sent=5.
- Empty FIFO, sched_valid=1, in_valid=1, in_data=0x1234:
  - Macro undefined -> underflow=1, state=ERROR, data_out=0, next-cycle occupancy=1.
  - Macro defined -> data_out=0x1234, words_sent=1, underflow=0, occupancy=0.
- ERROR with occupancy 4, assert flush with in_valid=1 and sched_valid=1 -> next cycle occupancy=0, underflow=0, state=IDLE, words_sent=0, pushed word dropped.
- Occupancy 2, tile_en=0 with sched_valid=1 for 3 cycles -> no pops, words_sent unchanged, in_ready=0; tile_en=1 resumes popping the same head word.
